islip_sched: RTL and testbench
==============================

// Module: islip_sched
// PURPOSE
//   Iterative round-robin (iSLIP-style) crossbar scheduler that sits in front of the
//   N x N priority-select / crossbar datapath and shares its outputs among the inputs.
//   Takes one request matrix per frame and runs up to ITER grant/accept iterations.
//   Returns a conflict-free grant matrix (at most one bit per row and per column)
//   that configures the crossbar. Fairness pointers persist across frames.
// PARAMETERS
//   N      4   number of inputs = number of outputs
//   ITER   2   maximum grant/accept iterations per frame (1..N)
//   PTRW   $clog2(N)  pointer width (localparam)
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   req_valid  in   1      request matrix valid
//   req_ready  out  1      scheduler can accept a request matrix
//   req        in   N x N  req[i][j]=1: input i wants output j
//   gnt_valid  out  1      grant matrix valid
//   gnt_ready  in   1      consumer takes the grant matrix
//   gnt        out  N x N  gnt[i][j]=1: input i connected to output j
//   busy       out  1      state != IDLE
// BEHAVIOUR
// - One clock (clk); reset is asynchronous and active-low (reset=0 resets).
// - Reset values: state=IDLE, all g_ptr[j]=0, all a_ptr[i]=0, match=0, iter_cnt=0,
//   gnt_valid=0, gnt=0, busy=0, req_ready=1.
// - FSM IDLE -> RUN -> DONE -> IDLE.
// - IDLE: req_ready=1.
//   - On req_valid&&req_ready: req_q<=req, match<=0, iter_cnt<=0, go to RUN.
// - RUN: one iteration per cycle; req_ready=0.
//   - Each output j not yet matched grants among unmatched inputs i with req_q[i][j].
//     Pick is round-robin starting at g_ptr[j].
//   - Each unmatched input accepts one of the grants it received.
//     Pick is round-robin starting at a_ptr[i].
//   - Accepted pairs are OR-ed into match.
//   - Pointer update occurs only in iteration 0, and only for accepted pairs:
//     g_ptr[j]<=(i+1)%N, a_ptr[i]<=(j+1)%N. Otherwise pointers are unchanged.
//   - Exit to DONE after the iteration that adds no new pair, or after the ITER-th
//     iteration, whichever comes first.
// - DONE: gnt_valid=1, gnt=match held stable; req_ready=0.
//   - On gnt_ready: go to IDLE.
// - gnt is forced to 0 whenever gnt_valid=0.
// - Latency: request accepted at edge E0; gnt_valid rises after edge Ek,
//   with k = iterations run (1..ITER).
// - Boundaries:
//   - All-zero req: k=1, gnt=0 (still delivered).
//   - A request is never accepted in RUN or DONE; a new frame is accepted the
//     cycle after the grant handshake.
//   - req changes after capture have no effect.
//   - Reset asserted mid-RUN or mid-DONE: frame dropped, all state returns to reset values.
// - Invariants:
//   - gnt is a subset of the captured req.
//   - popcount(gnt row) <= 1 and popcount(gnt column) <= 1.
// STRUCTURE
// - Shared package islip_pkg: state enum {IDLE,RUN,DONE}.
// - Sub-module rr_arb #(N): combinational N-way round-robin pick (req vector + pointer
//   -> one-hot grant + any).
//   - Instantiated N times for the grant stage and N times for the accept stage.
// TESTING (N=4, ITER=2; rows written as row[3:0])
// 1. After reset, req rows 0..3 = 1111,1110,1110,1110 -> after 2 cycles gnt_valid=1;
//    gnt rows = 0001,0010,0000,0000; g_ptr0=1, a_ptr0=1.
// 2. Repeat the same req immediately -> gnt rows = 0010,0100,0000,0000
//    (pointer rotation gives fairness).
// 3. All-zero req -> gnt_valid after 1 cycle, gnt=0; busy high for exactly 2 cycles.
// 4. Hold gnt_ready=0 for 5 cycles while pulsing req_valid -> gnt stable, req_ready=0,
//    no new capture. Raise gnt_ready -> IDLE, req_ready=1 the next cycle.
// 5. Assert reset during RUN of scenario 1 -> gnt_valid=0, req_ready=1 at once.
//    Rerun scenario 1 -> identical result (pointers were cleared).
// 6. 1000 random req frames -> check invariants, gnt subset of req, and k<=ITER.
//    No input starves over 8 repeats of a fixed full request.

Source files
------------

// File: rtl/islip_pkg.sv
// Shared types for the iSLIP crossbar scheduler.
package islip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/islip_sched_rr_arb.sv
// Combinational N-way round-robin arbiter: first set request at or after ptr_i wins.
module rr_arb
    import islip_pkg::*;
#(
    parameter int N = 4,
    localparam int PTRW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [PTRW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic            any_o
);

    always_comb begin
        logic            found;
        logic [PTRW-1:0] idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTRW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/islip_sched.sv
// iSLIP crossbar scheduler: up to ITER grant/accept rounds per request matrix,
// fairness pointers advance only on first-round matches and persist across frames.
module islip_sched
    import islip_pkg::*;
#(
    parameter int N    = 4,
    parameter int ITER = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [N-1:0][N-1:0]   req,
    output logic                  gnt_valid,
    input  logic                  gnt_ready,
    output logic [N-1:0][N-1:0]   gnt,
    output logic                  busy
);

    localparam int PTRW = $clog2(N);
    localparam int ICW  = $clog2(ITER + 1);

    state_e                 state_q, state_d;
    logic [N-1:0][N-1:0]    req_q, req_d;
    logic [N-1:0][N-1:0]    match_q, match_d;
    logic [ICW-1:0]         iter_cnt_q, iter_cnt_d;
    logic [N-1:0][PTRW-1:0] g_ptr_q, g_ptr_d;
    logic [N-1:0][PTRW-1:0] a_ptr_q, a_ptr_d;

    // g_* matrices are indexed [output][input], a_* matrices [input][output].
    logic [N-1:0][N-1:0]    match_t;
    logic [N-1:0][N-1:0]    g_req, g_oh;
    logic [N-1:0][N-1:0]    a_req, a_oh;
    logic [N-1:0]           in_free, out_free, g_any, a_any;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                assign match_t[gj][gi] = match_q[gi][gj];
                assign g_req[gj][gi]   = req_q[gi][gj] & in_free[gi] & out_free[gj];
                assign a_req[gi][gj]   = g_oh[gj][gi] & g_any[gj];
            end
            assign in_free[gi]  = ~|match_q[gi];
            assign out_free[gi] = ~|match_t[gi];

            rr_arb #(.N(N)) u_grant (
                .req_i (g_req[gi]),
                .ptr_i (g_ptr_q[gi]),
                .gnt_o (g_oh[gi]),
                .any_o (g_any[gi])
            );

            rr_arb #(.N(N)) u_accept (
                .req_i (a_req[gi]),
                .ptr_i (a_ptr_q[gi]),
                .gnt_o (a_oh[gi]),
                .any_o (a_any[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        match_d    = match_q;
        iter_cnt_d = iter_cnt_q;
        g_ptr_d    = g_ptr_q;
        a_ptr_d    = a_ptr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d      = req;
                    match_d    = '0;
                    iter_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                match_d    = match_q | a_oh;
                iter_cnt_d = iter_cnt_q + 1'b1;
                // Later rounds must not move pointers, otherwise fairness is lost.
                if (iter_cnt_q == '0) begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            if (a_oh[i][j]) begin
                                a_ptr_d[i] = PTRW'((j + 1) % N);
                                g_ptr_d[j] = PTRW'((i + 1) % N);
                            end
                        end
                    end
                end
                if (!(|a_any) || iter_cnt_q == ICW'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (gnt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            match_q    <= '0;
            iter_cnt_q <= '0;
            g_ptr_q    <= '0;
            a_ptr_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            match_q    <= match_d;
            iter_cnt_q <= iter_cnt_d;
            g_ptr_q    <= g_ptr_d;
            a_ptr_q    <= a_ptr_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign gnt_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign gnt       = gnt_valid ? match_q : '0;

endmodule

// File: tb/tb_islip_sched.sv
// Directed and randomized checks of islip_sched against an array-based iSLIP model.
module tb_islip_sched;

    localparam int N    = 4;
    localparam int ITER = 2;
    localparam int NN   = N * N;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                req_valid = 1'b0;
    logic                gnt_ready = 1'b1;
    logic [N-1:0][N-1:0] req = '0;
    logic                req_ready;
    logic                gnt_valid;
    logic                busy;
    logic [N-1:0][N-1:0] gnt;

    int vectors = 0;
    int miscompares = 0;
    int gp[N];
    int ap[N];

    islip_sched #(.N(N), .ITER(ITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .gnt       (gnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            gp[i] = 0;
            ap[i] = 0;
        end
    endtask

    // Outputs scan inputs from their grant pointer, inputs scan grants from their accept pointer.
    task automatic model_frame(input logic [N-1:0][N-1:0] r,
                               output logic [N-1:0][N-1:0] g, output int k);
        int in_m[N];
        int out_m[N];
        int gr[N];
        int added, ii, jj, pick;
        g = '0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            in_m[i]  = -1;
            out_m[i] = -1;
        end
        for (int it = 0; it < ITER; it++) begin
            k++;
            added = 0;
            for (int j = 0; j < N; j++) begin
                gr[j] = -1;
                if (out_m[j] < 0) begin
                    for (int o = 0; o < N; o++) begin
                        ii = (gp[j] + o) % N;
                        if (gr[j] < 0 && in_m[ii] < 0 && r[ii][j]) gr[j] = ii;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (in_m[i] < 0) begin
                    pick = -1;
                    for (int o = 0; o < N; o++) begin
                        jj = (ap[i] + o) % N;
                        if (pick < 0 && gr[jj] == i) pick = jj;
                    end
                    if (pick >= 0) begin
                        in_m[i]     = pick;
                        out_m[pick] = i;
                        g[i][pick]  = 1'b1;
                        added++;
                        if (it == 0) begin
                            gp[pick] = (i + 1) % N;
                            ap[i]    = (pick + 1) % N;
                        end
                    end
                end
            end
            if (added == 0) break;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic run_frame(input logic [N-1:0][N-1:0] r, input string tag, input int hold,
                             output logic [N-1:0][N-1:0] got);
        logic [N-1:0][N-1:0] eg;
        int ek, cyc, busy_cnt, maxpc, pc;
        model_frame(r, eg, ek);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req       = r;
        req_valid = 1'b1;
        gnt_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req       = NN'($urandom());
        cyc = 0;
        busy_cnt = 0;
        while (!gnt_valid && cyc < 8) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        if (gnt_valid && busy) busy_cnt++;
        chk({tag, "_gnt_valid"}, 32'(gnt_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(ek));
        chk({tag, "_k_le_iter"}, 32'(cyc <= ITER), 32'd1);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_subset"}, 32'(gnt & ~r), 32'd0);
        maxpc = 0;
        for (int i = 0; i < N; i++) begin
            if ($countones(gnt[i]) > maxpc) maxpc = $countones(gnt[i]);
            pc = 0;
            for (int j = 0; j < N; j++) pc += int'(gnt[j][i]);
            if (pc > maxpc) maxpc = pc;
        end
        chk({tag, "_conflict_free"}, 32'(maxpc <= 1), 32'd1);
        got = gnt;
        if (hold == 0) begin
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(ek + 1));
        end else begin
            for (int h = 0; h < hold; h++) begin
                req_valid = 1'b1;
                req       = NN'($urandom());
                @(posedge clk); #1;
                chk({tag, "_hold_gnt"}, 32'(gnt), 32'(eg));
                chk({tag, "_hold_valid"}, 32'(gnt_valid), 32'd1);
                chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            gnt_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_idle_gnt_valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_idle_gnt_zero"}, 32'(gnt), 32'd0);
        gnt_ready = 1'b1;
    endtask

    initial begin
        logic [N-1:0][N-1:0] s1;
        logic [N-1:0][N-1:0] got;
        logic [N-1:0][N-1:0] rnd;
        logic [N-1:0]        served;

        s1 = {4'b1110, 4'b1110, 4'b1110, 4'b1111};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_frame(s1, "s1", 0, got);
        chk("s1_expected_rows", 32'(got), 32'h0021);
        run_frame(s1, "s2", 0, got);
        chk("s2_rotated_rows", 32'(got), 32'h0042);
        run_frame('0, "s3_zero", 0, got);
        run_frame(s1, "s4_hold", 5, got);

        // Reset in the middle of RUN drops the frame and clears the pointers.
        chk("s5_req_ready", 32'(req_ready), 32'd1);
        req       = s1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("s5_busy_in_run", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("s5_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("s5_rst_req_ready", 32'(req_ready), 32'd1);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        model_reset();
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        run_frame(s1, "s5_rerun", 0, got);
        chk("s5_rerun_rows", 32'(got), 32'h0021);

        served = '0;
        for (int n = 0; n < 8; n++) begin
            run_frame('1, "fair", 0, got);
            for (int i = 0; i < N; i++) if (|got[i]) served[i] = 1'b1;
        end
        chk("fair_no_starvation", 32'(served), 32'hF);

        for (int n = 0; n < 1000; n++) begin
            rnd = NN'($urandom());
            if (n % 3 == 0) rnd = rnd & NN'($urandom());
            run_frame(rnd, "rand", int'($urandom_range(0, 2)), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
